// File: rtl/muldiv_issue_ctrl_if.sv
// Bus between the EX-stage issue controller and the multicycle multiply/divide calculator.
// The controller drives operands and the launch pulse; the calculator returns HI/LO and finish.
interface muldiv_issue_ctrl_if;
  logic [31:0] calc_a;
  logic [31:0] calc_b;
  logic [1:0]  calc_op;
  logic        calc_ena;
  logic [31:0] calc_lo;
  logic [31:0] calc_hi;
  logic        calc_finish;

  modport master (
    output calc_a, calc_b, calc_op, calc_ena,
    input  calc_lo, calc_hi, calc_finish
  );

  modport slave (
    input  calc_a, calc_b, calc_op, calc_ena,
    output calc_lo, calc_hi, calc_finish
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage initiator for the multicycle multiply/divide calculator; owns architectural HI/LO,
// stalls the pipeline while an operation is in flight and drains operations cancelled by flush.
//
// state | meaning
// IDLE  | accept MULT/MULTU/DIV/DIVU (latch operands) or MTHI/MTLO (write directly)
// ISSUE | calc_ena pulse, pipeline stalled
// ARM   | ignore stale calc_finish, load timeout counter
// WAIT  | stalled until calc_finish (commit) or timeout (abandon)
// DONE  | stall released so the instruction retires; EX inputs ignored
// DRAIN | flushed op still running in the calculator; result discarded
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_valid,
  input  logic [2:0]                 ex_op,
  input  logic [31:0]                ex_rs,
  input  logic [31:0]                ex_rt,
  input  logic                       flush,
  muldiv_issue_ctrl_if.master        calc,
  output logic [31:0]                hi,
  output logic [31:0]                lo,
  output logic                       stall,
  output logic                       hilo_busy,
  output logic                       timeout_err
);

  localparam logic [1:0] CAL_MULTU = 2'd1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, ARM, WAIT, DONE, DRAIN
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic          drain_armed;

  logic is_muldiv, is_mt, launch, mt_write;

  always_comb begin
    is_muldiv = ex_valid && (ex_op >= 3'd1) && (ex_op <= 3'd4);
    is_mt     = ex_valid && ((ex_op == 3'd5) || (ex_op == 3'd6));
    launch    = (state == IDLE) && is_muldiv && !flush;
    stall     = launch
             || (state == ISSUE) || (state == ARM) || (state == WAIT)
             || ((state == DRAIN) && (is_muldiv || is_mt));
    mt_write  = (state == IDLE) && is_mt && !flush && !stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hi             <= '0;
      lo             <= '0;
      calc.calc_a    <= '0;
      calc.calc_b    <= '0;
      calc.calc_op   <= CAL_MULTU;
      calc.calc_ena  <= 1'b0;
      hilo_busy      <= 1'b0;
      timeout_err    <= 1'b0;
      tmr            <= '0;
      drain_armed    <= 1'b0;
    end else begin
      calc.calc_ena <= 1'b0;
      timeout_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            calc.calc_a   <= ex_rs;
            calc.calc_b   <= ex_rt;
            calc.calc_op  <= 2'(ex_op - 3'd1);
            calc.calc_ena <= 1'b1;
            hilo_busy     <= 1'b1;
            state         <= ISSUE;
          end else if (mt_write) begin
            if (ex_op == 3'd5) hi <= ex_rs;
            else               lo <= ex_rs;
          end
        end
        ISSUE, ARM: begin
          // The calculator cannot be cancelled, so a flush only diverts into DRAIN.
          if (flush) begin
            state       <= DRAIN;
            drain_armed <= 1'b0;
            tmr         <= TMR_LOAD;
          end else if (state == ISSUE) begin
            state <= ARM;
          end else begin
            tmr   <= TMR_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state       <= DRAIN;
            drain_armed <= 1'b0;
            tmr         <= TMR_LOAD;
          end else if (calc.calc_finish) begin
            hi        <= calc.calc_hi;
            lo        <= calc.calc_lo;
            hilo_busy <= 1'b0;
            state     <= DONE;
          end else if (tmr == '0) begin
            timeout_err <= 1'b1;
            hilo_busy   <= 1'b0;
            state       <= DONE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          // First DRAIN cycle may still see finish from before the flush.
          drain_armed <= 1'b1;
          if (drain_armed && calc.calc_finish) begin
            hilo_busy <= 1'b0;
            state     <= IDLE;
          end else if (tmr == '0) begin
            timeout_err <= 1'b1;
            hilo_busy   <= 1'b0;
            state       <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl: a stub calculator answers from the DUT's calc bus,
// while expected HI/LO come from a scoreboard filled from the EX-side stimulus.
module tb_muldiv_issue_ctrl;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs, ex_rt;
  logic        flush;
  logic [31:0] hi, lo;
  logic        stall, hilo_busy, timeout_err;

  muldiv_issue_ctrl_if calc();

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .flush       (flush),
    .calc        (calc),
    .hi          (hi),
    .lo          (lo),
    .stall       (stall),
    .hilo_busy   (hilo_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] r;
    r = '0;
    case (op)
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp; end
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      3'd4: if (b != 0) r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] enc(input logic [2:0] op);
    case (op)
      3'd1: return 2'd0;
      3'd2: return 2'd1;
      3'd3: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cycle_start();
      ex_valid = 1'b0;
      flush = 1'b0;
      calc.calc_finish = 1'b0;
    end
  endtask

  task automatic do_muldiv(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input int fin_cyc, input bit stale, input string name);
    logic [63:0] got, exp;
    int cyc, stall_cnt, ena_cnt;
    bit stable, done;
    cyc = 0; stall_cnt = 0; ena_cnt = 0; stable = 1'b1; done = 1'b0;
    sb.push_back(model(op, rs, rt));
    while (!done && cyc < 200) begin
      cycle_start();
      if (cyc == 0) begin
        ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt; flush = 1'b0;
      end
      calc.calc_finish = 1'b0;
      if (stale && cyc <= 2) begin
        calc.calc_finish = 1'b1;
        calc.calc_hi = 32'hDEADBEEF;
        calc.calc_lo = 32'hBAADF00D;
      end
      if (cyc == 2 + fin_cyc) begin
        {calc.calc_hi, calc.calc_lo} = model(3'(calc.calc_op) + 3'd1, calc.calc_a, calc.calc_b);
        calc.calc_finish = 1'b1;
      end
      sample();
      if (stall) stall_cnt++;
      if (calc.calc_ena) ena_cnt += (cyc == 1) ? 1 : 100;
      if (cyc >= 1 && (calc.calc_a !== rs || calc.calc_b !== rt || calc.calc_op !== enc(op))) stable = 1'b0;
      if (cyc >= 1 && stall === 1'b0) done = 1'b1;
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done: stall never dropped within %0d cycles", name, cyc);
    end
    got = {hi, lo};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_hilo: got %h expected %h", name, got, exp);
    end
    checks++;
    if (stall_cnt !== 3 + fin_cyc) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, 3 + fin_cyc);
    end
    checks++;
    if (ena_cnt !== 1) begin
      errors++;
      $display("FAIL %s_ena_pulse: got score %0d expected 1", name, ena_cnt);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL %s_calc_stable: got %0d expected 1", name, stable);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; ex_op = 3'd0; ex_rs = '0; ex_rt = '0; flush = 1'b0;
    calc.calc_finish = 1'b0; calc.calc_hi = '0; calc.calc_lo = '0;
    repeat (3) sample();
    checks++;
    if ({hi, lo, calc.calc_a, calc.calc_b} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {hi, lo, calc.calc_a, calc.calc_b});
    end
    checks++;
    if ({calc.calc_ena, stall, hilo_busy, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {calc.calc_ena, stall, hilo_busy, timeout_err});
    end
    checks++;
    if (calc.calc_op !== 2'd1) begin
      errors++;
      $display("FAIL reset_calc_op: got %0d expected 1", calc.calc_op);
    end
    cycle_start();
    reset = 1'b0;
  endtask

  task automatic test_mult();
    do_muldiv(3'd1, 32'hFFFFFFFD, 32'd5, 3, 1'b0, "mult_neg");
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      errors++;
      $display("FAIL mult_const: got %h expected FFFFFFFFFFFFFFF1", {hi, lo});
    end
    idle(1);
  endtask

  task automatic test_divu();
    do_muldiv(3'd4, 32'd100, 32'd7, 2, 1'b0, "divu");
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL divu_const: got hi %0d lo %0d expected hi 2 lo 14", hi, lo);
    end
    idle(1);
  endtask

  task automatic test_stale_finish();
    do_muldiv(3'd2, 32'hFFFFFFFF, 32'd2, 2, 1'b1, "stale_finish");
    idle(1);
  endtask

  task automatic test_back_to_back();
    do_muldiv(3'd3, 32'hFFFFFF9C, 32'd7, 1, 1'b0, "b2b_div");
    do_muldiv(3'd1, 32'h00012345, 32'hFFFF0000, 4, 1'b0, "b2b_mult");
    idle(1);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      b = (op >= 3'd3) ? 32'($urandom_range(1, 1000)) : $urandom;
      do_muldiv(op, a, b, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), "random");
      idle(1);
    end
  endtask

  task automatic test_mt();
    cycle_start();
    ex_valid = 1'b1; ex_op = 3'd5; ex_rs = 32'h12345678; flush = 1'b0;
    sample();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    cycle_start();
    ex_op = 3'd6; ex_rs = 32'h9ABCDEF0;
    sample();
    checks++;
    if (stall !== 1'b0 || hi !== 32'h12345678) begin
      errors++;
      $display("FAIL mthi_value: got stall %b hi %h expected 0 12345678", stall, hi);
    end
    cycle_start();
    ex_valid = 1'b0;
    sample();
    checks++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin
      errors++;
      $display("FAIL mtlo_value: got hi %h lo %h expected 12345678 9ABCDEF0", hi, lo);
    end
  endtask

  task automatic test_flush_idle();
    logic [31:0] hi0;
    hi0 = hi;
    cycle_start();
    ex_valid = 1'b1; ex_op = 3'd3; ex_rs = 32'd9; ex_rt = 32'd3; flush = 1'b1;
    sample();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
    cycle_start();
    ex_op = 3'd5; ex_rs = 32'hFFFF0000;
    sample();
    checks++;
    if (calc.calc_ena !== 1'b0 || hilo_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_issue: got ena %b busy %b expected 0 0", calc.calc_ena, hilo_busy);
    end
    cycle_start();
    ex_valid = 1'b0; flush = 1'b0;
    sample();
    checks++;
    if (hi !== hi0) begin errors++; $display("FAIL flush_idle_mthi: got %h expected %h", hi, hi0); end
  endtask

  task automatic test_flush_wait();
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    cycle_start();
    ex_valid = 1'b1; ex_op = 3'd2; ex_rs = 32'd7; ex_rt = 32'd9; flush = 1'b0; calc.calc_finish = 1'b0;
    repeat (3) cycle_start();
    cycle_start();
    flush = 1'b1;
    sample();
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL flush_wait_stall: got %b expected 1", stall); end
    cycle_start();
    flush = 1'b0; ex_valid = 1'b0;
    calc.calc_finish = 1'b1; calc.calc_hi = 32'h11111111; calc.calc_lo = 32'h22222222;
    sample();
    checks++;
    if (stall !== 1'b0 || hilo_busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_first: got stall %b busy %b expected 0 1", stall, hilo_busy);
    end
    cycle_start();
    ex_valid = 1'b1; ex_op = 3'd6; ex_rs = 32'h00000055;
    sample();
    checks++;
    if (stall !== 1'b1 || hilo_busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_second: got stall %b busy %b expected 1 1", stall, hilo_busy);
    end
    cycle_start();
    calc.calc_finish = 1'b0;
    sample();
    checks++;
    if (hilo_busy !== 1'b0 || stall !== 1'b0 || hi !== hi0 || lo !== lo0) begin
      errors++;
      $display("FAIL drain_exit: got busy %b stall %b hi %h lo %h expected 0 0 %h %h",
               hilo_busy, stall, hi, lo, hi0, lo0);
    end
    cycle_start();
    ex_valid = 1'b0;
    sample();
    checks++;
    if (lo !== 32'h00000055) begin errors++; $display("FAIL drain_mtlo: got %h expected 00000055", lo); end
  endtask

  task automatic test_timeout();
    logic [31:0] hi0, lo0;
    bit bad_pulse, bad_stall;
    hi0 = hi; lo0 = lo; bad_pulse = 1'b0; bad_stall = 1'b0;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      cycle_start();
      if (cyc == 0) begin
        ex_valid = 1'b1; ex_op = 3'd4; ex_rs = 32'd50; ex_rt = 32'd3; flush = 1'b0; calc.calc_finish = 1'b0;
      end
      if (cyc == 12) ex_valid = 1'b0;
      sample();
      if (timeout_err !== ((cyc == 3 + TMO) ? 1'b1 : 1'b0)) bad_pulse = 1'b1;
      if (stall !== ((cyc <= 2 + TMO) ? 1'b1 : 1'b0)) bad_stall = 1'b1;
    end
    checks++;
    if (bad_pulse) begin errors++; $display("FAIL timeout_pulse: got misplaced pulse expected cycle %0d only", 3 + TMO); end
    checks++;
    if (bad_stall) begin errors++; $display("FAIL timeout_stall: got wrong stall window expected cycles 0..%0d", 2 + TMO); end
    checks++;
    if (hi !== hi0 || lo !== lo0) begin
      errors++;
      $display("FAIL timeout_hilo: got %h %h expected %h %h", hi, lo, hi0, lo0);
    end
  endtask

  task automatic test_reset_mid_wait();
    cycle_start();
    ex_valid = 1'b1; ex_op = 3'd1; ex_rs = 32'd3; ex_rt = 32'd4; flush = 1'b0; calc.calc_finish = 1'b0;
    repeat (4) cycle_start();
    #2;
    reset = 1'b1; ex_valid = 1'b0;
    #1;
    checks++;
    if ({hi, lo, calc.calc_a, calc.calc_b} !== 128'd0 || calc.calc_op !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_data: got %h op %0d expected 0 op 1", {hi, lo, calc.calc_a, calc.calc_b}, calc.calc_op);
    end
    checks++;
    if ({calc.calc_ena, stall, hilo_busy, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_flags: got %b expected 0000", {calc.calc_ena, stall, hilo_busy, timeout_err});
    end
    cycle_start();
    reset = 1'b0;
    calc.calc_finish = 1'b1; calc.calc_hi = 32'hAAAAAAAA; calc.calc_lo = 32'h55555555;
    cycle_start();
    sample();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || hilo_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_late_finish: got hi %h lo %h busy %b expected 0 0 0", hi, lo, hilo_busy);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_stale_finish();
    test_back_to_back();
    test_random();
    test_mt();
    test_flush_idle();
    test_flush_wait();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
